// File: rtl/fetch_redirect_controller.sv
`default_nettype none
// ============================================================================
// fetch_redirect_controller
// Fetch sequencer with branch redirect, stale-response discard and a one-entry
// skid buffer. Define REDIRECT_COUNTER_EN to add the redirect_count output.
// Revision: 1.0
// ============================================================================

package fetch_redirect_pkg;
    typedef enum logic {
        PcPlus4             = 1'b0,
        PcOrReadDataPlusImm = 1'b1
    } pc_src_t;
endpackage

module fetch_redirect_controller
    import fetch_redirect_pkg::*;
#(
    parameter int unsigned      Width       = 64,
    parameter logic [Width-1:0] ResetVector = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  pc_src_t          pc_src,
    input  logic [Width-1:0] branch_target,
    input  logic             stall,
    output logic             fetch_req,
    output logic [Width-1:0] fetch_addr,
    input  logic             fetch_ack,
    input  logic [31:0]      fetch_data,
    output logic             inst_valid,
    output logic [31:0]      inst,
    output logic [Width-1:0] inst_pc,
    output logic             flush
`ifdef REDIRECT_COUNTER_EN
    ,
    output logic [31:0]      redirect_count
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic [Width-1:0] PcStep = Width'(4);

    state_t           state_q, state_d;
    logic [Width-1:0] pc_q, pc_d;
    logic [Width-1:0] addr_q, addr_d;
    logic             inst_valid_q, inst_valid_d;
    logic [31:0]      inst_q, inst_d;
    logic [Width-1:0] inst_pc_q, inst_pc_d;
    logic [31:0]      skid_inst_q, skid_inst_d;
    logic [Width-1:0] skid_pc_q, skid_pc_d;
    logic             redirect;

    assign redirect   = (pc_src == PcOrReadDataPlusImm);
    assign flush      = redirect;
    assign fetch_req  = (state_q == REQ) || (state_q == DISCARD);
    // DISCARD keeps presenting the abandoned address until its ack arrives
    assign fetch_addr = (state_q == DISCARD) ? addr_q : pc_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        inst_valid_d = inst_valid_q & stall;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (fetch_ack && !redirect) begin
                    pc_d = pc_q + PcStep;
                    if (stall && inst_valid_q) begin
                        skid_inst_d = fetch_data;
                        skid_pc_d   = pc_q;
                        state_d     = HOLD;
                    end else begin
                        inst_d       = fetch_data;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                    end
                end else if (redirect && !fetch_ack) begin
                    addr_d  = pc_q;
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (fetch_ack) begin
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_d = REQ;
                end else if (!stall) begin
                    inst_d       = skid_inst_q;
                    inst_pc_d    = skid_pc_q;
                    inst_valid_d = 1'b1;
                    state_d      = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        if (redirect) begin
            pc_d         = branch_target;
            inst_valid_d = 1'b0;
            skid_inst_d  = '0;
            skid_pc_d    = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pc_q         <= ResetVector;
            addr_q       <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            skid_inst_q  <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

`ifdef REDIRECT_COUNTER_EN
    logic [31:0] redirect_count_q, redirect_count_d;

    assign redirect_count_d = redirect_count_q + {31'd0, redirect};
    assign redirect_count   = redirect_count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            redirect_count_q <= '0;
        end else begin
            redirect_count_q <= redirect_count_d;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_redirect_controller.sv
`default_nettype none
// Self-checking bench for fetch_redirect_controller: directed scenarios with
// hand-derived expectations, then random traffic against a behavioural model.

module tb_fetch_redirect_controller;
    import fetch_redirect_pkg::*;

    localparam pc_src_t P = PcPlus4;
    localparam pc_src_t J = PcOrReadDataPlusImm;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    pc_src_t     pc_src = PcPlus4;
    logic [63:0] branch_target = '0;
    logic        stall = 1'b0;
    logic        fetch_req;
    logic [63:0] fetch_addr;
    logic        fetch_ack = 1'b0;
    logic [31:0] fetch_data = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        flush;
`ifdef REDIRECT_COUNTER_EN
    logic [31:0] redirect_count;
`endif

    int vecs = 0;
    int fails = 0;

    fetch_redirect_controller #(.Width(64), .ResetVector(64'h1000)) dut (
        .clock(clock), .reset_n(reset_n), .pc_src(pc_src), .branch_target(branch_target),
        .stall(stall), .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
        .fetch_data(fetch_data), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
`ifdef REDIRECT_COUNTER_EN
        .redirect_count(redirect_count),
`endif
        .flush(flush)
    );

    always #5 clock = ~clock;

    // Behavioural model: a PC, one outstanding-request "kill" flag and a queue of held fetches.
    typedef struct packed {
        logic [31:0] i;
        logic [63:0] a;
    } ent_t;

    bit          m_idle, m_kill, m_valid;
    logic [63:0] m_pc, m_req_addr, m_inst_pc;
    logic [31:0] m_inst, m_cnt;
    ent_t        m_skid[$];

    function automatic bit exp_req();
        return !m_idle && (m_skid.size() == 0);
    endfunction

    function automatic logic [63:0] exp_addr();
        return m_kill ? m_req_addr : m_pc;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        bit   rdir, acc, req_now, old_valid;
        ent_t e;
        if (!reset_n) begin
            m_idle = 1; m_kill = 0; m_valid = 0; m_pc = 64'h1000; m_req_addr = '0;
            m_inst = '0; m_inst_pc = '0; m_cnt = '0; m_skid.delete();
        end else begin
            rdir = (pc_src == PcOrReadDataPlusImm);
            req_now = exp_req();
            acc = fetch_ack && req_now;
            old_valid = m_valid;
            if (!stall) m_valid = 0;
            if (m_idle) begin
                m_idle = 0;
            end else if (m_skid.size() > 0) begin
                if (!stall) begin
                    e = m_skid.pop_front();
                    m_inst = e.i; m_inst_pc = e.a; m_valid = 1;
                end
            end else if (acc) begin
                if (m_kill) begin
                    m_kill = 0;
                end else if (!rdir) begin
                    if (!stall || !old_valid) begin
                        m_inst = fetch_data; m_inst_pc = m_pc; m_valid = 1;
                    end else begin
                        m_skid.push_back('{fetch_data, m_pc});
                    end
                    m_pc = m_pc + 64'd4;
                end
            end
            if (rdir) begin
                if (req_now && !acc && !m_kill) begin
                    m_kill = 1; m_req_addr = m_pc;
                end
                m_pc = branch_target; m_valid = 0; m_skid.delete();
                m_cnt = m_cnt + 1;
            end
        end
    end

    task automatic drive(input pc_src_t ps, input logic [63:0] tgt, input logic st,
                         input logic ack, input logic [31:0] d);
        @(negedge clock);
        pc_src = ps; branch_target = tgt; stall = st; fetch_ack = ack; fetch_data = d;
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(P, '0, 1'b0, 1'b0, '0);
        drive(P, '0, 1'b0, 1'b0, '0);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(P, '0, 1'b0, 1'b0, '0);
        drive(P, '0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        vecs++; if (fetch_req !== 1'b0 || inst_valid !== 1'b0)
            begin fails++; $display("FAIL rst_ctrl: req=%b valid=%b want 0/0", fetch_req, inst_valid); end
        vecs++; if (inst !== 32'd0 || inst_pc !== 64'd0)
            begin fails++; $display("FAIL rst_data: inst=%h pc=%h want 0/0", inst, inst_pc); end
        vecs++; if (flush !== 1'b0)
            begin fails++; $display("FAIL rst_flush: flush=%b want 0", flush); end
        reset_n = 1'b1;
        #1;
        vecs++; if (fetch_req !== 1'b0)
            begin fails++; $display("FAIL idle_req: req=%b want 0", fetch_req); end
    endtask

    task automatic test_sequential_fetch();
        drive(P, '0, 1'b0, 1'b1, 32'h1111_0000);
        vecs++; if (fetch_req !== 1'b1 || fetch_addr !== 64'h1000 || inst_valid !== 1'b0)
            begin fails++; $display("FAIL seq0: req=%b addr=%h valid=%b want 1/1000/0", fetch_req, fetch_addr, inst_valid); end
        drive(P, '0, 1'b0, 1'b1, 32'h1111_0004);
        vecs++; if (fetch_addr !== 64'h1004 || inst_valid !== 1'b1 || inst !== 32'h1111_0000 || inst_pc !== 64'h1000)
            begin fails++; $display("FAIL seq1: addr=%h valid=%b inst=%h pc=%h want 1004/1/11110000/1000", fetch_addr, inst_valid, inst, inst_pc); end
        drive(P, '0, 1'b0, 1'b0, '0);
        vecs++; if (fetch_addr !== 64'h1008 || inst !== 32'h1111_0004 || inst_pc !== 64'h1004)
            begin fails++; $display("FAIL seq2: addr=%h inst=%h pc=%h want 1008/11110004/1004", fetch_addr, inst, inst_pc); end
    endtask

    task automatic test_redirect_outstanding();
        drive(J, 64'h2000, 1'b0, 1'b0, '0);
        vecs++; if (flush !== 1'b1 || inst_valid !== 1'b0 || fetch_req !== 1'b1 || fetch_addr !== 64'h1008)
            begin fails++; $display("FAIL redir_a: flush=%b valid=%b req=%b addr=%h want 1/0/1/1008", flush, inst_valid, fetch_req, fetch_addr); end
        drive(P, '0, 1'b0, 1'b0, '0);
        vecs++; if (flush !== 1'b0 || fetch_req !== 1'b1 || fetch_addr !== 64'h1008 || inst_valid !== 1'b0)
            begin fails++; $display("FAIL discard_hold: flush=%b req=%b addr=%h valid=%b want 0/1/1008/0", flush, fetch_req, fetch_addr, inst_valid); end
        drive(P, '0, 1'b0, 1'b1, 32'hBAD0_1008);
        vecs++; if (fetch_req !== 1'b1 || fetch_addr !== 64'h1008)
            begin fails++; $display("FAIL discard_ack: req=%b addr=%h want 1/1008", fetch_req, fetch_addr); end
        drive(P, '0, 1'b0, 1'b1, 32'h2222_0000);
        vecs++; if (fetch_req !== 1'b1 || fetch_addr !== 64'h2000 || inst_valid !== 1'b0)
            begin fails++; $display("FAIL redir_target: req=%b addr=%h valid=%b want 1/2000/0", fetch_req, fetch_addr, inst_valid); end
    endtask

    task automatic test_redirect_with_ack();
        drive(J, 64'h3000, 1'b0, 1'b1, 32'h2222_0004);
        vecs++; if (flush !== 1'b1 || inst_valid !== 1'b1 || inst !== 32'h2222_0000 || fetch_addr !== 64'h2004)
            begin fails++; $display("FAIL ack_redir_a: flush=%b valid=%b inst=%h addr=%h want 1/1/22220000/2004", flush, inst_valid, inst, fetch_addr); end
        drive(P, '0, 1'b0, 1'b1, 32'h3333_0000);
        vecs++; if (fetch_req !== 1'b1 || fetch_addr !== 64'h3000 || inst_valid !== 1'b0)
            begin fails++; $display("FAIL ack_redir_b: req=%b addr=%h valid=%b want 1/3000/0", fetch_req, fetch_addr, inst_valid); end
    endtask

    task automatic test_stall_hold();
        drive(P, '0, 1'b1, 1'b1, 32'h3333_0004);
        vecs++; if (fetch_req !== 1'b1 || fetch_addr !== 64'h3004 || inst_valid !== 1'b1 || inst_pc !== 64'h3000)
            begin fails++; $display("FAIL hold_pre: req=%b addr=%h valid=%b pc=%h want 1/3004/1/3000", fetch_req, fetch_addr, inst_valid, inst_pc); end
        drive(P, '0, 1'b1, 1'b1, 32'hBAD0_0000);
        vecs++; if (fetch_req !== 1'b0 || inst_valid !== 1'b1 || inst !== 32'h3333_0000 || inst_pc !== 64'h3000)
            begin fails++; $display("FAIL hold_a: req=%b valid=%b inst=%h pc=%h want 0/1/33330000/3000", fetch_req, inst_valid, inst, inst_pc); end
        drive(P, '0, 1'b0, 1'b0, '0);
        vecs++; if (fetch_req !== 1'b0 || inst !== 32'h3333_0000 || inst_pc !== 64'h3000)
            begin fails++; $display("FAIL hold_b: req=%b inst=%h pc=%h want 0/33330000/3000", fetch_req, inst, inst_pc); end
        drive(J, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b1, 32'hBAD0_3008);
        vecs++; if (fetch_req !== 1'b1 || fetch_addr !== 64'h3008 || inst_valid !== 1'b1 || inst !== 32'h3333_0004 || inst_pc !== 64'h3004)
            begin fails++; $display("FAIL hold_release: req=%b addr=%h valid=%b inst=%h pc=%h want 1/3008/1/33330004/3004", fetch_req, fetch_addr, inst_valid, inst, inst_pc); end
    endtask

    task automatic test_pc_wrap();
        drive(P, '0, 1'b0, 1'b1, 32'h4444_0000);
        vecs++; if (fetch_req !== 1'b1 || fetch_addr !== 64'hFFFF_FFFF_FFFF_FFFC || inst_valid !== 1'b0)
            begin fails++; $display("FAIL wrap_a: req=%b addr=%h valid=%b want 1/fffffffffffffffc/0", fetch_req, fetch_addr, inst_valid); end
        drive(P, '0, 1'b0, 1'b0, '0);
        vecs++; if (fetch_addr !== 64'h0 || inst_valid !== 1'b1 || inst !== 32'h4444_0000 || inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC)
            begin fails++; $display("FAIL wrap_b: addr=%h valid=%b inst=%h pc=%h want 0/1/44440000/fffffffffffffffc", fetch_addr, inst_valid, inst, inst_pc); end
    endtask

    task automatic test_reset_mid_request();
        reset_n = 1'b0;
        #1;
        vecs++; if (fetch_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'd0 || inst_pc !== 64'd0)
            begin fails++; $display("FAIL async_rst: req=%b valid=%b inst=%h pc=%h want 0/0/0/0", fetch_req, inst_valid, inst, inst_pc); end
        drive(P, '0, 1'b0, 1'b1, 32'hBAD0_0000);
        reset_n = 1'b1;
        #1;
        vecs++; if (fetch_req !== 1'b0)
            begin fails++; $display("FAIL idle_late_ack: req=%b want 0", fetch_req); end
        drive(P, '0, 1'b0, 1'b0, '0);
        vecs++; if (fetch_req !== 1'b1 || fetch_addr !== 64'h1000 || inst_valid !== 1'b0)
            begin fails++; $display("FAIL post_rst: req=%b addr=%h valid=%b want 1/1000/0", fetch_req, fetch_addr, inst_valid); end
    endtask

    task automatic test_random();
        pc_src_t     ps;
        logic [63:0] tgt;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            ps  = ($urandom_range(0, 99) < 15) ? J : P;
            tgt = {$urandom(), $urandom()} & ~64'd3;
            drive(ps, tgt, ($urandom_range(0, 99) < 40), 1'($urandom_range(0, 1)), $urandom());
            vecs++; if (fetch_req !== exp_req() || flush !== (ps == J) || inst_valid !== m_valid)
                begin fails++; $display("FAIL rnd_ctrl[%0d]: req=%b flush=%b valid=%b want %b/%b/%b", n, fetch_req, flush, inst_valid, exp_req(), ps == J, m_valid); end
            if (exp_req()) begin
                vecs++; if (fetch_addr !== exp_addr())
                    begin fails++; $display("FAIL rnd_addr[%0d]: addr=%h want %h", n, fetch_addr, exp_addr()); end
            end
            if (m_valid) begin
                vecs++; if (inst !== m_inst || inst_pc !== m_inst_pc)
                    begin fails++; $display("FAIL rnd_inst[%0d]: inst=%h pc=%h want %h/%h", n, inst, inst_pc, m_inst, m_inst_pc); end
            end
`ifdef REDIRECT_COUNTER_EN
            vecs++; if (redirect_count !== m_cnt)
                begin fails++; $display("FAIL rnd_count[%0d]: count=%0d want %0d", n, redirect_count, m_cnt); end
`endif
        end
    endtask

`ifdef REDIRECT_COUNTER_EN
    task automatic test_redirect_count();
        do_reset();
        drive(J, 64'h5000, 1'b0, 1'b0, '0);
        drive(J, 64'h6000, 1'b0, 1'b0, '0);
        drive(J, 64'h7000, 1'b0, 1'b1, '0);
        drive(P, '0, 1'b0, 1'b0, '0);
        vecs++; if (redirect_count !== 32'd3)
            begin fails++; $display("FAIL count3: count=%0d want 3", redirect_count); end
        reset_n = 1'b0;
        #1;
        vecs++; if (redirect_count !== 32'd0)
            begin fails++; $display("FAIL count_rst: count=%0d want 0", redirect_count); end
        reset_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_sequential_fetch();
        test_redirect_outstanding();
        test_redirect_with_ack();
        test_stall_hold();
        test_pc_wrap();
        test_reset_mid_request();
        test_random();
`ifdef REDIRECT_COUNTER_EN
        test_redirect_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

`default_nettype wire
